// File: rtl/ch_frame_sched.sv
// Multi-channel I/Q frame scheduler: latches all channels on a strobe and serialises them as I0,Q0,I1,Q1,...
// into a FIFO. Define CH_FRAME_HDR_EN to prefix each frame with a {8'hA5, seq} header word.
`timescale 1ns/1ps
module ch_frame_sched #(
  parameter int unsigned NCH_MAX = 4,
  parameter int unsigned DW      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    strobe,
  input  logic [2:0]              num_ch,
  input  logic [NCH_MAX*2*DW-1:0] sample_in,
  input  logic                    fifo_full,
  input  logic                    clr_ovr,
  output logic                    wr_en,
  output logic [DW-1:0]           wr_data,
  output logic [2:0]              channel,
  output logic                    busy,
  output logic                    overrun,
  output logic [15:0]             drop_cnt
);

  localparam int unsigned SW = NCH_MAX * 2 * DW;
  localparam int unsigned CW = 3;

`ifdef CH_FRAME_HDR_EN
  typedef enum logic [1:0] {IDLE, EMIT_I, EMIT_Q, HDR} state_t;
`else
  typedef enum logic [1:0] {IDLE, EMIT_I, EMIT_Q} state_t;
`endif

  state_t          state_q, state_d;
  logic [SW-1:0]   lat_q, lat_d;
  logic [CW-1:0]   chan_q, chan_d;
  logic [CW-1:0]   last_q, last_d;
  logic [DW-1:0]   data_q, data_d;
  logic            ovr_q, ovr_d;
  logic [15:0]     drop_q, drop_d;
`ifdef CH_FRAME_HDR_EN
  logic [7:0]      seq_q, seq_d;
`endif
  logic [CW-1:0]   eff_last;
  logic            drop;

  function automatic logic [DW-1:0] i_of(input logic [SW-1:0] v, input logic [CW-1:0] ch);
    return v[int'(ch)*2*DW + DW +: DW];
  endfunction

  function automatic logic [DW-1:0] q_of(input logic [SW-1:0] v, input logic [CW-1:0] ch);
    return v[int'(ch)*2*DW +: DW];
  endfunction

  // Index of the last active channel after clamping num_ch to 1..NCH_MAX
  always_comb begin
    if (num_ch == 3'd0)
      eff_last = '0;
    else if (32'(num_ch) > NCH_MAX)
      eff_last = CW'(NCH_MAX - 1);
    else
      eff_last = num_ch - 3'd1;
  end

  assign busy     = (state_q != IDLE);
  assign wr_en    = busy && !fifo_full;
  assign wr_data  = data_q;
  assign channel  = chan_q;
  assign overrun  = ovr_q;
  assign drop_cnt = drop_q;
  assign drop     = strobe && busy;

  // data_q always holds the word for the current emit state, so a stall simply holds everything
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    chan_d  = chan_q;
    last_d  = last_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    drop_d  = drop_q;
`ifdef CH_FRAME_HDR_EN
    seq_d   = seq_q;
`endif

    case (state_q)
      IDLE: begin
        if (strobe && enable) begin
          lat_d  = sample_in;
          last_d = eff_last;
          chan_d = '0;
`ifdef CH_FRAME_HDR_EN
          state_d = HDR;
          data_d  = DW'({8'hA5, seq_q});
`else
          state_d = EMIT_I;
          data_d  = i_of(sample_in, '0);
`endif
        end
      end
`ifdef CH_FRAME_HDR_EN
      HDR: begin
        if (!fifo_full) begin
          state_d = EMIT_I;
          data_d  = i_of(lat_q, chan_q);
          seq_d   = seq_q + 8'd1;
        end
      end
`endif
      EMIT_I: begin
        if (!fifo_full) begin
          state_d = EMIT_Q;
          data_d  = q_of(lat_q, chan_q);
        end
      end
      EMIT_Q: begin
        if (!fifo_full) begin
          if (chan_q == last_q) begin
            state_d = IDLE;
            chan_d  = '0;
            data_d  = '0;
          end else begin
            state_d = EMIT_I;
            chan_d  = chan_q + 3'd1;
            data_d  = i_of(lat_q, chan_q + 3'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A drop in the same cycle as a clear restarts the count at one
    if (drop) begin
      ovr_d  = 1'b1;
      drop_d = clr_ovr ? 16'd1 : ((drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1);
    end else if (clr_ovr) begin
      ovr_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q   <= '0;
      chan_q  <= '0;
      last_q  <= '0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
      drop_q  <= '0;
`ifdef CH_FRAME_HDR_EN
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      chan_q  <= chan_d;
      last_q  <= last_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
      drop_q  <= drop_d;
`ifdef CH_FRAME_HDR_EN
      seq_q   <= seq_d;
`endif
    end
  end

endmodule

// File: tb/tb_ch_frame_sched.sv
// Bench for ch_frame_sched: directed scenarios plus random traffic, checked against a word-queue model.
`timescale 1ns/1ps
module tb_ch_frame_sched;

  localparam int unsigned NCH_MAX = 4;
  localparam int unsigned DW      = 16;
  localparam int unsigned SW      = NCH_MAX * 2 * DW;

  logic          clk = 1'b0;
  logic          reset, enable, strobe, fifo_full, clr_ovr;
  logic [2:0]    num_ch;
  logic [SW-1:0] sample_in;
  logic          wr_en, busy, overrun;
  logic [DW-1:0] wr_data;
  logic [2:0]    channel;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  ch_frame_sched #(.NCH_MAX(NCH_MAX), .DW(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .strobe(strobe), .num_ch(num_ch),
    .sample_in(sample_in), .fifo_full(fifo_full), .clr_ovr(clr_ovr),
    .wr_en(wr_en), .wr_data(wr_data), .channel(channel), .busy(busy),
    .overrun(overrun), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [DW-1:0] w;
    int unsigned   ch;
    bit            hdr;
  } word_t;

  word_t       pend[$];
  bit          m_ovr     = 1'b0;
  int unsigned m_cnt     = 0;
  int unsigned m_seq     = 0;
  bit          data_zero = 1'b1;
  int          tests     = 0;
  int          fails     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned eff(input logic [2:0] n);
    if (n == 3'd0) return 1;
    if (int'(n) > int'(NCH_MAX)) return NCH_MAX;
    return int'(n);
  endfunction

  function automatic logic [SW-1:0] rnd_smp();
    logic [SW-1:0] r;
    for (int i = 0; i < int'(SW / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic push_frame(input logic [2:0] nc, input logic [SW-1:0] smp);
`ifdef CH_FRAME_HDR_EN
    pend.push_back('{w: DW'({8'hA5, 8'(m_seq)}), ch: 0, hdr: 1'b1});
`endif
    for (int k = 0; k < int'(eff(nc)); k++) begin
      pend.push_back('{w: smp[k*2*DW + DW +: DW], ch: k, hdr: 1'b0});
      pend.push_back('{w: smp[k*2*DW +: DW],      ch: k, hdr: 1'b0});
    end
    data_zero = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model, clock
  task automatic cycle(input bit st, input bit en, input bit ff, input bit clr, input bit rst,
                       input logic [2:0] nc, input logic [SW-1:0] smp);
    bit busy_m, wr_m;
    strobe = st; enable = en; fifo_full = ff; clr_ovr = clr; reset = rst;
    num_ch = nc; sample_in = smp;
    #1;
    busy_m = (pend.size() != 0);
    wr_m   = busy_m && !ff;
    chk("busy", 32'(busy), 32'(busy_m));
    chk("wr_en", 32'(wr_en), 32'(wr_m));
    chk("channel", 32'(channel), busy_m ? pend[0].ch : 0);
    if (busy_m) chk("wr_data", 32'(wr_data), 32'(pend[0].w));
    else if (data_zero) chk("wr_data_idle", 32'(wr_data), 0);
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("drop_cnt", 32'(drop_cnt), m_cnt);
    if (wr_m) begin
      if (pend[0].hdr) m_seq = (m_seq + 1) % 256;
      pend.delete(0);
    end
    if (rst) begin
      pend.delete();
      m_ovr = 1'b0; m_cnt = 0; m_seq = 0; data_zero = 1'b1;
    end else begin
      if (st && busy_m) begin
        m_ovr = 1'b1;
        m_cnt = clr ? 1 : ((m_cnt == 65535) ? 65535 : m_cnt + 1);
      end else if (clr) begin
        m_ovr = 1'b0; m_cnt = 0;
      end
      if (st && !busy_m && en) push_frame(nc, smp);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit en = 1'b1);
    for (int i = 0; i < n; i++) cycle(1'b0, en, 1'b0, 1'b0, 1'b0, 3'd2, rnd_smp());
  endtask

  initial begin
    logic [SW-1:0] s;
    int guard;
    reset = 1'b1; enable = 1'b0; strobe = 1'b0; fifo_full = 1'b0; clr_ovr = 1'b0;
    num_ch = 3'd0; sample_in = '0;
    @(posedge clk);
    @(negedge clk);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, '0);
    idle(2);

    // Two-channel frame, no stalls
    s = rnd_smp();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, s);
    idle(6);

    // Four channels, FIFO full for three cycles after the second word
    s = rnd_smp();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, s);
    idle(2);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, s);
    idle(8);

    // Back-to-back strobes: second one dropped, then cleared
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, rnd_smp());
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, rnd_smp());
    idle(2);
    chk("ovr_after_drop", 32'(overrun), 1);
    chk("cnt_after_drop", 32'(drop_cnt), 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, rnd_smp());
    idle(1);
    chk("ovr_after_clr", 32'(overrun), 0);

    // Clamped channel counts
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, rnd_smp());
    idle(4);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, rnd_smp());
    idle(10);

    // Strobe with enable low is ignored; enable dropping mid-frame does not abort
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, rnd_smp());
    idle(1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, rnd_smp());
    idle(8, 1'b0);

    // Reset after the second word of a four-channel frame
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, rnd_smp());
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, rnd_smp());
    idle(4);

    // Drops accumulate, then a drop coinciding with clear leaves a count of one
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, rnd_smp());
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, rnd_smp());
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, rnd_smp());
    chk("cnt_two", 32'(drop_cnt), 2);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, rnd_smp());
    idle(6);
    chk("ovr_drop_clr", 32'(overrun), 1);
    chk("cnt_drop_clr", 32'(drop_cnt), 1);

    // Random traffic
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(3) == 0, $urandom_range(3) != 0, $urandom_range(3) == 0,
            $urandom_range(15) == 0, $urandom_range(99) == 0, 3'($urandom_range(7)), rnd_smp());
    idle(20);

    // Long run of single-channel frames (exercises header sequence wrap when enabled)
    for (int f = 0; f < 257; f++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, rnd_smp());
      guard = 0;
      while (pend.size() != 0 && guard < 20) begin
        idle(1);
        guard++;
      end
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
